instr_fifo: RTL and testbench
=============================

# instr_fifo

Instruction queue between the dual-issue arbiter and each execution lane; the arbiter drives one instance through its per-lane enable (FIFO_1_en / FIFO_2_en) and its instr_out bus. The block buffers 32-bit instructions in order and presents them to the lane's decode stage through a registered read port. It reports occupancy, almost-full back-pressure and the most recently accepted instruction. The arbiter uses that last instruction for register-collision steering.

## Interface

Parameters:
- DATA_W, 32, instruction width
- DEPTH, 8, number of entries; power of two, minimum 4
- AF_LEVEL, DEPTH-2, count at or above which almost_full asserts

Ports:
- clk  in  1  rising-edge clock; the single clock of the block
- resetn  in  1  asynchronous, active-low reset
- wr_en  in  1  write request, driven by the arbiter's FIFO_n_en
- din  in  DATA_W  write data, driven by the arbiter's instr_out
- rd_en  in  1  read request from the lane decode stage
- dout  out  DATA_W  registered read data
- dout_valid  out  1  dout holds a freshly popped word this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy
- last_instr  out  DATA_W  last word accepted by a write
- overflow  out  1  sticky flag: a write was dropped
- ovf_clr  in  1  synchronous clear for overflow

## Operation

- Storage: DEPTH x DATA_W register array, write pointer wp and read pointer rp, each $clog2(DEPTH) bits. Both pointers wrap modulo DEPTH naturally.
- Write accepted (wa) = wr_en && (!full || rd_en). On wa, mem[wp] <= din, wp <= wp+1 and last_instr <= din.
- Read accepted (ra) = rd_en && !empty. On ra, dout <= mem[rp] and rp <= rp+1. dout_valid <= ra every cycle.
- count <= count + wa - ra. Simultaneous wa and ra leaves count unchanged.
- Full with rd_en and wr_en together: both are accepted. The popped word is the oldest entry. The new word goes into the freed slot.
- Empty with wr_en and rd_en together: the write is accepted and the read is ignored, with no fall-through. dout_valid stays 0 and count becomes 1.
- Write while full without rd_en: the word is dropped and mem, wp, last_instr and count are unchanged. overflow <= 1.
- Read while empty: ignored. rp and dout are unchanged and dout_valid is 0. No flag is raised.
- overflow: set by a dropped write and cleared by ovf_clr. If a drop and ovf_clr occur in the same cycle, set wins.
- dout holds its last popped value when there is no read.
- full, empty and almost_full are decoded from the registered count, so they are registered-equivalent and glitch-free.

## Timing

- Reset (resetn low, asynchronous): wp=0, rp=0, count=0, dout=0, dout_valid=0, last_instr=0, overflow=0, empty=1, full=0, almost_full=0. Array contents are not cleared.
- Reset mid-operation: all queued words are discarded immediately. After release, the first read of valid data requires a new write.
- Write-to-read latency: a word written at edge N makes empty=0 after N. A read asserted in the cycle after N is accepted at edge N+1. The word appears on dout with dout_valid=1 after edge N+1.
- Read latency: 1 cycle from the accepting edge to dout/dout_valid.
- Flags and count reflect all operations up to and including the most recent edge.
- Back-pressure contract: the arbiter must stop steering to this lane while almost_full=1. This gives 2 cycles of slack for in-flight writes.

## Test plan

- Reset then idle: hold resetn=0 for 2 cycles, then release. Required: empty=1, count=0, dout=0, dout_valid=0, last_instr=0, overflow=0.
- Ordering: write 32'h00045678, 32'h0005678a and 32'h000678ab on consecutive cycles, then read 3 times. Required: dout_valid pulses with dout in the same order, last_instr=32'h000678ab, and empty=1 at the end.
- Fill and overflow (DEPTH=8): write 8 words. Required: almost_full=1 at count=6 and full=1 at count=8. A 9th write of 32'hDEADBEEF is dropped: overflow=1, last_instr unchanged and count=8. Asserting ovf_clr for 1 cycle then gives overflow=0.
- Full with simultaneous read and write: from full, assert wr_en with 32'h0008abcd and rd_en together. Required: the oldest word appears on dout and count stays 8. Draining all 8 entries returns 32'h0008abcd last.
- Empty with simultaneous read and write: from empty, assert wr_en with 32'h000abcde and rd_en. Required: dout_valid=0 and count=1. The next read returns 32'h000abcde.
- Wrap-around and async reset: perform 20 interleaved writes and reads so the pointers wrap twice, and check data integrity throughout. Then pulse resetn low mid-cycle with count=3. Required: count=0 and empty=1 immediately, before the next edge, and dout=0.

Source files
------------

// File: rtl/instr_fifo.sv
// instr_fifo: in-order instruction queue between the dual-issue arbiter and one
// execution lane. Registered read port, occupancy flags decoded from the
// registered count, sticky overflow flag and a copy of the last accepted word.
module instr_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          din,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          dout,
  output logic                       dout_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DATA_W-1:0]          last_instr,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic              wa;
  logic              ra;
  logic              drop;

  // A full queue still takes a write when the same cycle pops a word, so the
  // new word lands in the slot being freed. An empty queue never falls through.
  assign wa   = wr_en && (!full || rd_en);
  assign ra   = rd_en && !empty;
  assign drop = wr_en && !wa;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AF_LEVEL));

  // Storage array: written on every accepted write, never reset.
  always_ff @(posedge clk) begin
    if (wa) begin
      mem[wp] <= din;
    end
  end

  // Pointers, occupancy, read port, last-accepted word and sticky overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      last_instr <= '0;
      overflow   <= 1'b0;
    end else begin
      dout_valid <= ra;
      if (wa) begin
        wp         <= wp + AW'(1);
        last_instr <= din;
      end
      if (ra) begin
        rp   <= rp + AW'(1);
        dout <= mem[rp];
      end
      case ({wa, ra})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fifo.sv
// Directed plus randomized bench for instr_fifo with a queue-based reference.
module tb_instr_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int AF     = DEPTH - 2;

  logic              clk = 1'b0;
  logic              resetn;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [3:0]        count;
  logic [DATA_W-1:0] last_instr;
  logic              overflow;
  logic              ovf_clr;

  int errors = 0;
  int checks = 0;

  // reference state
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_dout;
  logic              m_dv;
  logic [DATA_W-1:0] m_last;
  logic              m_ovf;

  instr_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .last_instr(last_instr),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_last = '0;
    m_ovf  = 1'b0;
  endtask

  // One cycle of queue behaviour: decisions use the occupancy before the edge.
  task automatic model_step(input logic w, input logic [31:0] d, input logic r, input logic c);
    bit rd_ok, wr_ok;
    rd_ok = r && (q.size() > 0);
    wr_ok = w && ((q.size() < DEPTH) || r);
    m_dv = rd_ok;
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) begin
      q.push_back(d);
      m_last = d;
    end
    if (w && !wr_ok) m_ovf = 1'b1;
    else if (c)      m_ovf = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},  32'(count),       32'(q.size()));
    chk({tag, ".empty"},  32'(empty),       32'(q.size() == 0));
    chk({tag, ".full"},   32'(full),        32'(q.size() == DEPTH));
    chk({tag, ".afull"},  32'(almost_full), 32'(q.size() >= AF));
    chk({tag, ".dv"},     32'(dout_valid),  32'(m_dv));
    chk({tag, ".dout"},   dout,             m_dout);
    chk({tag, ".last"},   last_instr,       m_last);
    chk({tag, ".ovf"},    32'(overflow),    32'(m_ovf));
  endtask

  task automatic cyc(input string tag, input logic w, input logic [31:0] d,
                     input logic r, input logic c);
    wr_en   = w;
    din     = d;
    rd_en   = r;
    ovf_clr = c;
    model_step(w, d, r, c);
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic w, r;
    logic [31:0] d;
    int writes;

    resetn = 1'b0; wr_en = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; din = '0;
    model_reset();

    // Reset then idle
    @(posedge clk); @(posedge clk); #1;
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.dout",  dout, 32'd0);
    chk("rst.dv",    32'(dout_valid), 32'd0);
    chk("rst.last",  last_instr, 32'd0);
    chk("rst.ovf",   32'(overflow), 32'd0);
    chk("rst.full",  32'(full), 32'd0);
    resetn = 1'b1;
    cyc("idle", 1'b0, '0, 1'b0, 1'b0);

    // Read while empty is ignored
    cyc("rd_empty", 1'b0, '0, 1'b1, 1'b0);

    // Ordering
    cyc("ord_w0", 1'b1, 32'h00045678, 1'b0, 1'b0);
    cyc("ord_w1", 1'b1, 32'h0005678a, 1'b0, 1'b0);
    cyc("ord_w2", 1'b1, 32'h000678ab, 1'b0, 1'b0);
    chk("ord.last_const", last_instr, 32'h000678ab);
    cyc("ord_r0", 1'b0, '0, 1'b1, 1'b0);
    chk("ord.d0", dout, 32'h00045678);
    cyc("ord_r1", 1'b0, '0, 1'b1, 1'b0);
    chk("ord.d1", dout, 32'h0005678a);
    cyc("ord_r2", 1'b0, '0, 1'b1, 1'b0);
    chk("ord.d2", dout, 32'h000678ab);
    chk("ord.empty_const", 32'(empty), 32'd1);
    cyc("ord_hold", 1'b0, '0, 1'b0, 1'b0);
    chk("ord.hold_dout", dout, 32'h000678ab);

    // Fill and overflow
    for (int i = 0; i < DEPTH; i++) begin
      cyc("fill", 1'b1, 32'h10000000 + 32'(i), 1'b0, 1'b0);
      if (i == AF - 2) chk("fill.af_below", 32'(almost_full), 32'd0);
      if (i == AF - 1) chk("fill.af_at",    32'(almost_full), 32'd1);
    end
    chk("fill.full_const", 32'(full), 32'd1);
    cyc("ovf_drop", 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("ovf.flag",  32'(overflow), 32'd1);
    chk("ovf.last",  last_instr, 32'h10000007);
    chk("ovf.count", 32'(count), 32'd8);
    cyc("ovf_drop_clr", 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    chk("ovf.set_wins", 32'(overflow), 32'd1);
    cyc("ovf_clr", 1'b0, '0, 1'b0, 1'b1);
    chk("ovf.cleared", 32'(overflow), 32'd0);

    // Full with simultaneous read and write
    cyc("full_rw", 1'b1, 32'h0008abcd, 1'b1, 1'b0);
    chk("full_rw.dout",  dout, 32'h10000000);
    chk("full_rw.count", 32'(count), 32'd8);
    for (int i = 0; i < DEPTH; i++) cyc("drain", 1'b0, '0, 1'b1, 1'b0);
    chk("drain.lastword", dout, 32'h0008abcd);

    // Empty with simultaneous read and write
    cyc("empty_rw", 1'b1, 32'h000abcde, 1'b1, 1'b0);
    chk("empty_rw.dv",    32'(dout_valid), 32'd0);
    chk("empty_rw.count", 32'(count), 32'd1);
    cyc("empty_rw_rd", 1'b0, '0, 1'b1, 1'b0);
    chk("empty_rw.data", dout, 32'h000abcde);

    // Randomized interleaving; enough writes to wrap the pointers repeatedly
    writes = 0;
    for (int i = 0; i < 200; i++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      d = $urandom;
      if (w) writes++;
      cyc("rand", w, d, r, ($urandom_range(0, 15) == 0));
    end
    chk("rand.wrapped", 32'(writes >= 2 * DEPTH + 4), 32'd1);

    // Bring occupancy to 3, then asynchronous reset between edges
    while (q.size() > 0) cyc("pre_rst_drain", 1'b0, '0, 1'b1, 1'b0);
    cyc("pre_rst_w0", 1'b1, 32'h0000a001, 1'b0, 1'b0);
    cyc("pre_rst_w1", 1'b1, 32'h0000a002, 1'b0, 1'b0);
    cyc("pre_rst_w2", 1'b1, 32'h0000a003, 1'b0, 1'b0);
    chk("pre_rst.count", 32'(count), 32'd3);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    chk("arst.count", 32'(count), 32'd0);
    chk("arst.empty", 32'(empty), 32'd1);
    chk("arst.dout",  dout, 32'd0);
    chk("arst.dv",    32'(dout_valid), 32'd0);
    #2;
    resetn = 1'b1;
    cyc("post_rst_rd", 1'b0, '0, 1'b1, 1'b0);
    chk("post_rst.no_data", 32'(dout_valid), 32'd0);
    cyc("post_rst_w", 1'b1, 32'h0000b00b, 1'b0, 1'b0);
    cyc("post_rst_r", 1'b0, '0, 1'b1, 1'b0);
    chk("post_rst.data", dout, 32'h0000b00b);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
